// File: rtl/md_sequencer.sv
// md_sequencer: multi-cycle mult/div controller owning HI/LO and the MD stall request
module md_sequencer #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic        we_hilo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_md_family,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] res_hi, res_lo;
  logic        dz;
  logic        sa, sb;
  logic [31:0] a, b, uq, ur, q, r;
  logic [63:0] ea, eb, prod, nxt;
  // result datapath: divide on magnitudes then restore signs so the 0x80000000/-1 case needs no special path
  always_comb begin
    sa   = ~op[0] & rs_val[31];
    sb   = ~op[0] & rt_val[31];
    a    = sa ? -rs_val : rs_val;
    b    = (rt_val == 32'd0) ? 32'd1 : (sb ? -rt_val : rt_val);
    uq   = a / b;
    ur   = a % b;
    q    = (sa ^ sb) ? -uq : uq;
    r    = sa ? -ur : ur;
    ea   = {{32{sa}}, rs_val};
    eb   = {{32{sb}}, rt_val};
    prod = ea * eb;
    nxt  = op[1] ? {r, q} : prod;
  end
  // sequencer: latch result on accept, count down in RUN, commit on the last busy edge
  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      res_hi <= 32'd0;
      res_lo <= 32'd0;
      dz     <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else if (state == IDLE) begin
      if (start) begin
        if (!op[2]) begin
          {res_hi, res_lo} <= nxt;
          dz    <= op[1] & (rt_val == 32'd0);
          cnt   <= op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
          state <= RUN;
        end
      end else if (we_hilo) begin
        if (op == 3'd4) hi <= rs_val;
        if (op == 3'd5) lo <= rs_val;
      end
    end else begin
      cnt <= cnt - 4'd1;
      if (cnt == 4'd1) begin
        if (!dz) begin
          hi <= res_hi;
          lo <= res_lo;
        end
        state <= IDLE;
      end
    end
  end
  assign busy     = (state == RUN);
  assign md_stall = d_md_family & (start | busy);
endmodule

// File: tb/tb_md_sequencer.sv
// tb_md_sequencer: randomized self-checking bench with a behavioural HI/LO model
module tb_md_sequencer;
  logic        clk = 0, reset = 1, start = 0, we_hilo = 0, d_md_family = 0;
  logic [2:0]  op = 0;
  logic [31:0] rs_val = 0, rt_val = 0;
  logic        busy, md_stall;
  logic [31:0] hi, lo;
  int          checks = 0, fails = 0;
  logic [31:0] mhi = 0, mlo = 0;

  md_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .we_hilo(we_hilo),
    .rs_val(rs_val), .rt_val(rt_val), .d_md_family(d_md_family),
    .busy(busy), .hi(hi), .lo(lo), .md_stall(md_stall)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic void model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [63:0] p;
    longint      sx, sy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'd0: begin p = 64'(sx * sy); {mhi, mlo} = p; end
      3'd1: begin p = {32'd0, x} * {32'd0, y}; {mhi, mlo} = p; end
      3'd2: if (y != 0) begin mlo = 32'(sx / sy); mhi = 32'(sx % sy); end
      3'd3: if (y != 0) begin mlo = x / y; mhi = x % y; end
      3'd4: mhi = x;
      3'd5: mlo = x;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                       output int n, output int stall_bad);
    stall_bad = 0;
    op = o; rs_val = x; rt_val = y; start = 1; d_md_family = 1;
    #1;
    if (md_stall !== 1'b1) stall_bad++;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (busy === 1'b1 && n < 20) begin
      if (md_stall !== 1'b1) stall_bad++;
      n++;
      tick();
    end
    d_md_family = 0;
  endtask

  task automatic test_reset;
    start = 1; op = 0; rs_val = $urandom; rt_val = $urandom; reset = 0;
    tick(); tick();
    start = 0; reset = 1; d_md_family = 1;
    #1;
    mhi = 0; mlo = 0;
    checks++; if (hi !== 32'd0) begin fails++; $display("FAIL reset hi: got %h expected 0", hi); end
    checks++; if (lo !== 32'd0) begin fails++; $display("FAIL reset lo: got %h expected 0", lo); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++; if (md_stall !== 1'b0) begin fails++; $display("FAIL reset md_stall: got %b expected 0", md_stall); end
    d_md_family = 0;
  endtask

  task automatic test_arith(input string name, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    int n, sbad, want;
    want = o[1] ? 10 : 5;
    do_op(o, x, y, n, sbad);
    model(o, x, y);
    checks++; if (n != want) begin fails++; $display("FAIL %s busy cycles: got %0d expected %0d", name, n, want); end
    checks++; if (sbad != 0) begin fails++; $display("FAIL %s md_stall low in %0d stall cycles, expected 0", name, sbad); end
    checks++; if (hi !== mhi) begin fails++; $display("FAIL %s hi: got %h expected %h", name, hi, mhi); end
    checks++; if (lo !== mlo) begin fails++; $display("FAIL %s lo: got %h expected %h", name, lo, mlo); end
  endtask

  task automatic test_mthi;
    op = 3'd4; rs_val = 32'h1234_5678; we_hilo = 1;
    #1;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi busy pre: got %b expected 0", busy); end
    tick();
    we_hilo = 0;
    model(3'd4, 32'h1234_5678, 0);
    checks++; if (hi !== mhi) begin fails++; $display("FAIL mthi hi: got %h expected %h", hi, mhi); end
    checks++; if (lo !== mlo) begin fails++; $display("FAIL mthi lo: got %h expected %h", lo, mlo); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mthi busy: got %b expected 0", busy); end
  endtask

  task automatic test_mt_in_run;
    logic [31:0] x, y;
    int n;
    x = $urandom; y = $urandom;
    op = 0; rs_val = x; rt_val = y; start = 1;
    tick();
    start = 0; op = 3'd5; rs_val = 32'hDEAD_BEEF; we_hilo = 1;
    n = 1;
    tick();
    we_hilo = 0;
    while (busy === 1'b1 && n < 20) begin n++; tick(); end
    model(3'd0, x, y);
    checks++; if (n != 5) begin fails++; $display("FAIL mt_in_run busy cycles: got %0d expected 5", n); end
    checks++; if (hi !== mhi) begin fails++; $display("FAIL mt_in_run hi: got %h expected %h", hi, mhi); end
    checks++; if (lo !== mlo) begin fails++; $display("FAIL mt_in_run lo: got %h expected %h", lo, mlo); end
  endtask

  task automatic test_start_and_mt;
    op = 3'd4; rs_val = 32'hA5A5_0F0F; start = 1; we_hilo = 1;
    tick();
    start = 0; we_hilo = 0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL start_and_mt busy: got %b expected 0", busy); end
    checks++; if (hi !== mhi) begin fails++; $display("FAIL start_and_mt hi: got %h expected %h", hi, mhi); end
  endtask

  task automatic test_reset_mid_run;
    op = 3'd2; rs_val = $urandom; rt_val = 32'($urandom_range(1, 1000)); start = 1;
    tick();
    start = 0;
    tick(); tick();
    reset = 0;
    tick();
    reset = 1;
    mhi = 0; mlo = 0;
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_run busy: got %b expected 0", busy); end
    checks++; if (hi !== mhi) begin fails++; $display("FAIL reset_mid_run hi: got %h expected 0", hi); end
    checks++; if (lo !== mlo) begin fails++; $display("FAIL reset_mid_run lo: got %h expected 0", lo); end
    repeat (15) tick();
    checks++; if ({hi, lo} !== {mhi, mlo}) begin fails++; $display("FAIL reset_mid_run late commit: got %h_%h expected 0", hi, lo); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_mid_run late busy: got %b expected 0", busy); end
  endtask

  task automatic test_back_to_back;
    logic [2:0]  o;
    logic [31:0] x, y;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      x = pick(); y = pick();
      if (o < 3'd4) test_arith("b2b", o, x, y);
      else begin
        op = o; rs_val = x; we_hilo = 1;
        tick();
        we_hilo = 0;
        model(o, x, 0);
        checks++; if ({hi, lo} !== {mhi, mlo}) begin fails++; $display("FAIL b2b mt op%0d: got %h_%h expected %h_%h", o, hi, lo, mhi, mlo); end
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b mt busy: got %b expected 0", busy); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_arith("mult", 3'd0, 32'hFFFF_FFFE, 32'h0000_0003);
    test_arith("multu", 3'd1, 32'hFFFF_FFFE, 32'h0000_0003);
    test_arith("div", 3'd2, 32'hFFFF_FFF9, 32'h0000_0002);
    test_arith("divu_zero", 3'd3, 32'h0000_0007, 32'h0000_0000);
    test_arith("div_zero", 3'd2, 32'h8000_0000, 32'h0000_0000);
    test_arith("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    test_mthi();
    test_mt_in_run();
    test_start_and_mt();
    test_reset_mid_run();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
